// File: rtl/any1_dmem_ctrl.sv
// ANY-1 data-memory controller: turns an effective address into one or two
// WISHBONE-style bus beats, merges split load data and sign/zero-extends it.
module any1_dmem_ctrl #(
    parameter int AWID = 32,
    parameter int TMO  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    output logic            rdy,
    input  logic            st,
    input  logic [1:0]      sz,
    input  logic            uns,
    input  logic [AWID-1:0] ea,
    input  logic [63:0]     sdat,
    output logic            done,
    output logic [63:0]     ldat,
    output logic            fault,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [7:0]      sel_o,
    output logic [AWID-1:0] adr_o,
    output logic [63:0]     dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [63:0]     dat_i
);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;

    state_t          state, state_nxt;
    logic            st_r, uns_r, fault_r;
    logic [1:0]      sz_r;
    logic [AWID-1:0] ea_r;
    logic [63:0]     sdat_r, capt;
    logic [15:0]     mask;
    logic [7:0]      tmo_cnt;

    logic [5:0]      lsh;
    logic [6:0]      rsh;
    logic [AWID-1:0] adr_base;
    logic            bus_fail;

    // Byte-lane mask spanning two consecutive 8-byte words.
    function automatic logic [15:0] mask_of(input logic [1:0] s, input logic [2:0] off);
        logic [15:0] base;
        case (s)
            2'd0:    base = 16'h0001;
            2'd1:    base = 16'h0003;
            2'd2:    base = 16'h000F;
            default: base = 16'h00FF;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] s, input logic u);
        case (s)
            2'd0:    return {{56{~u & v[7]}},  v[7:0]};
            2'd1:    return {{48{~u & v[15]}}, v[15:0]};
            2'd2:    return {{32{~u & v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    assign lsh      = {ea_r[2:0], 3'b000};
    assign rsh      = 7'd64 - {1'b0, lsh};
    assign adr_base = {ea_r[AWID-1:3], 3'b000};
    // Error beats acknowledge; a timeout only counts when ack is absent.
    assign bus_fail = err_i || (!ack_i && (tmo_cnt == 8'(TMO - 1)));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_r    <= 1'b0;
            uns_r   <= 1'b0;
            sz_r    <= 2'd0;
            ea_r    <= '0;
            sdat_r  <= 64'd0;
            mask    <= 16'd0;
            capt    <= 64'd0;
            fault_r <= 1'b0;
            tmo_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    st_r    <= st;
                    uns_r   <= uns;
                    sz_r    <= sz;
                    ea_r    <= ea;
                    sdat_r  <= sdat;
                    mask    <= mask_of(sz, ea[2:0]);
                    capt    <= 64'd0;
                    fault_r <= 1'b0;
                    tmo_cnt <= 8'd0;
                end
                BEAT1: begin
                    if (bus_fail) fault_r <= 1'b1;
                    else if (ack_i) begin
                        capt    <= dat_i >> lsh;
                        tmo_cnt <= 8'd0;
                    end else tmo_cnt <= tmo_cnt + 8'd1;
                end
                BEAT2: begin
                    if (bus_fail) fault_r <= 1'b1;
                    else if (ack_i) capt <= capt | (dat_i << rsh);
                    else tmo_cnt <= tmo_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;
        ldat      = 64'd0;
        cyc_o     = 1'b0;
        stb_o     = 1'b0;
        we_o      = 1'b0;
        sel_o     = 8'd0;
        adr_o     = '0;
        dat_o     = 64'd0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (req) state_nxt = BEAT1;
            end
            BEAT1: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = st_r;
                adr_o = adr_base;
                sel_o = mask[7:0];
                dat_o = sdat_r << lsh;
                if (bus_fail)   state_nxt = DONE;
                else if (ack_i) state_nxt = (mask[15:8] != 8'd0) ? BEAT2 : DONE;
            end
            BEAT2: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = st_r;
                adr_o = adr_base + AWID'(8);
                sel_o = mask[15:8];
                dat_o = sdat_r >> rsh;
                if (bus_fail || ack_i) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                fault     = fault_r;
                ldat      = (fault_r || st_r) ? 64'd0 : extend(capt, sz_r, uns_r);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/any1_dmem_ctrl.md
Name: any1_dmem_ctrl

Overview:
- Data-memory controller that consumes the effective address produced by the ANY-1 address generator.
- Performs the corresponding load or store as a single-master WISHBONE-style bus transaction.
- Splits accesses that cross an 8-byte boundary into two beats and merges/aligns the data.
- Sign- or zero-extends load results, and returns result/fault to the pipeline with a one-cycle done pulse.

Parameters:
- AWID, 32, address width (matches the Address type).
- TMO, 255, bus-cycle timeout in clocks without ack/err before a fault is raised; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  1  request valid; sampled only when rdy=1
- rdy  out  1  controller idle, can accept req
- st  in  1  1=store, 0=load
- sz  in  2  access size: 0=byte, 1=wyde(16), 2=tetra(32), 3=octa(64); same encoding as the agen scale
- uns  in  1  load zero-extend (1) or sign-extend (0)
- ea  in  AWID  effective address
- sdat  in  64  store data, right-justified
- done  out  1  one-cycle pulse: operation complete
- ldat  out  64  extended load result; valid with done
- fault  out  1  valid with done: bus err or timeout
- cyc_o  out  1  bus cycle
- stb_o  out  1  strobe
- we_o  out  1  write enable
- sel_o  out  8  byte lane selects
- adr_o  out  AWID  bus address, always 8-byte aligned
- dat_o  out  64  bus write data
- ack_i  in  1  bus acknowledge
- err_i  in  1  bus error
- dat_i  in  64  bus read data

Behaviour:
- Reset (synchronous):
  - Next edge forces state IDLE, rdy=1, done=0, fault=0, ldat=0, cyc_o=stb_o=we_o=0, sel_o=0, adr_o=0, dat_o=0, timeout counter=0.
  - Reset mid-transaction abandons the access; no done pulse is issued.
- States: IDLE, BEAT1, BEAT2, DONE.
- IDLE:
  - rdy=1.
  - On req, latch st/sz/uns/ea/sdat, compute a 16-bit mask m = ((1<<(1<<sz))-1) << ea[2:0], go to BEAT1.
- BEAT1:
  - cyc_o=stb_o=1, we_o=st, adr_o={ea[AWID-1:3],000}, sel_o=m[7:0].
  - dat_o = sdat << (8*ea[2:0]).
  - Holds until ack_i or err_i.
  - On ack with m[15:8]!=0, go to BEAT2 (cyc_o stays 1, stb_o stays 1, no idle cycle); otherwise go to DONE.
  - Load: beat data captured as dat_i >> (8*ea[2:0]).
- BEAT2:
  - adr_o = BEAT1 address + 8 (wraps modulo 2^AWID), sel_o=m[15:8].
  - dat_o = sdat >> (8*(8-ea[2:0])).
  - Load: dat_i << (8*(8-ea[2:0])) is ORed into the captured value.
  - On ack or err, go to DONE.
- DONE:
  - cyc_o=stb_o=we_o=0, sel_o=0, done=1 for exactly one cycle, then IDLE.
  - rdy stays 0 in DONE, so back-to-back requests are spaced by at least one cycle.
- Load extension:
  - Result is masked to 8/16/32/64 bits.
  - uns=0 replicates bit 7/15/31/63; uns=1 zero-fills.
  - Stores return ldat=0.
- Fault handling:
  - err_i in either beat terminates immediately (no BEAT2); in DONE, fault=1 and ldat=0.
  - Timeout counter clears on entry to each beat and increments each beat cycle without ack/err; reaching TMO has the same effect as err_i.
  - If ack_i and err_i are both high in the same cycle, err wins.
- Latency:
  - With ack in the first stb cycle, an aligned access is: req at T0, stb at T1, done at T2.
  - A split access adds one cycle per extra beat.
- Signals ignored outside their states:
  - req is ignored when rdy=0.
  - ack_i/err_i are ignored outside BEAT1/BEAT2.

Test Plan:
- Aligned octa load: ea=0x100, sz=3, dat_i=0x8877665544332211, ack same cycle -> adr_o=0x100, sel_o=0xFF, done at T2, ldat=0x8877665544332211, fault=0.
- Signed byte load: ea=0x203, sz=0, uns=0, dat_i byte3=0x80 -> sel_o=0x08, ldat=0xFFFFFFFFFFFFFF80; repeat with uns=1 -> ldat=0x80.
- Split tetra store: ea=0x1006, sz=2, sdat=0xAABBCCDD -> beat1 adr_o=0x1000, sel_o=0xC0, dat_o[63:48]=0xCCDD; beat2 adr_o=0x1008, sel_o=0x03, dat_o[15:0]=0xAABB; single done.
- Split wyde load with ack delayed 3 cycles per beat: ea=0x7, byte7=0x34, next-word byte0=0x12 -> ldat=0x1234, stb_o held high through the waits, done 1 cycle after the second ack.
- err_i asserted in BEAT1 of a split access -> no BEAT2, done with fault=1 and ldat=0; separately, no ack for TMO=4 cycles -> fault=1.
- rst asserted while in BEAT1 -> next cycle cyc_o=0, rdy=1, and no done pulse ever appears for that request.
